frame_window_reader: RTL
========================

// Module: frame_window_reader
// PURPOSE
//  Read-side initiator for the 3-row frame buffer. It sweeps the buffered rows left to right and
//  issues single-pixel reads. It assembles each 3x3 neighbourhood into a window register and hands
//  it downstream through a valid/ready handshake. Sits between frame_buffer and the edge-detection
//  (Sobel) kernel.
// PARAMETERS
//  P_COLUMNS      640  columns per row (>=3); frame_buffer column count
//  P_PIXEL_DEPTH  8    bits per pixel read from the buffer
//  (row count fixed at 3; localparam L_ROWS = 3)
// PORTS
//  I_CLK            in   1               clock
//  I_RESET          in   1               asynchronous, active-high reset
//  I_START          in   1               begin sweep; sampled only in IDLE
//  O_FB_COL         out  $clog2(P_COLUMNS) read column to frame_buffer
//  O_FB_ROW         out  2               read row to frame_buffer (0..2)
//  O_FB_READ_ENABLE out  1               read strobe to frame_buffer
//  I_FB_PIXEL       in   P_PIXEL_DEPTH   frame_buffer O_PIXEL (1-cycle registered latency)
//  O_WINDOW         out  9*P_PIXEL_DEPTH window; slot (r*3+k) = row r, col center-1+k
//  O_WINDOW_VALID   out  1               window valid; held until accepted
//  I_WINDOW_READY   in   1               downstream accepts on VALID&READY
//  O_CENTER_COL     out  $clog2(P_COLUMNS) centre column of current window (1..P_COLUMNS-2)
//  O_BUSY           out  1               high in every state except IDLE
//  O_DONE           out  1               one-cycle pulse after final window accepted
// BEHAVIOUR
//  - Reset (async): all outputs 0; state IDLE; counters, window and capture pipe cleared.
//  - States: IDLE -> FETCH -> WAIT -> VALID -> (FETCH | DONE); DONE -> IDLE after 1 cycle.
//  - IDLE: I_START=1 -> FETCH with fetch count 9 (cols 0..2), fetch col 0, row 0.
//  - FETCH: O_FB_READ_ENABLE=1 each cycle. Address = counters (combinational from regs). Order is
//    row 0,1,2 within a column, then col+1. After the last issue -> WAIT.
//  - Capture pipe: cap_valid/cap_row register the issued read. In the next cycle I_FB_PIXEL is
//    written to slot (cap_row*3+2). Capturing row 0 first shifts all three rows left by one slot.
//  - WAIT: final capture occurs; -> VALID. O_WINDOW_VALID is registered high from VALID entry.
//  - Timing: I_START in cycle 0 -> reads in cycles 1-9, O_WINDOW_VALID first high in cycle 11.
//    Accept in cycle t -> reads t+1..t+3, valid again in t+5.
//  - VALID: O_WINDOW and O_CENTER_COL stable and O_FB_READ_ENABLE=0 while READY=0.
//    - On accept with O_CENTER_COL==P_COLUMNS-2: VALID drops and the block goes to DONE (O_DONE=1).
//    - Otherwise: VALID drops, O_CENTER_COL+1, and the block goes to FETCH with count 3 at the next
//      column.
//  - Windows per sweep: P_COLUMNS-2. Counters never wrap past P_COLUMNS-1.
//  - I_START outside IDLE is ignored; I_START held high in IDLE restarts a sweep after DONE.
//  - Never drives writes. Integration holds frame_buffer I_WRITE_ENABLE=0 and I_ENABLE=1 while
//    O_BUSY=1; otherwise captured data is undefined.
//  - Reset mid-operation: immediate return to IDLE with all outputs 0; no partial window emitted.
// STRUCTURE
//  - Shared package edge_pkg: state encoding localparams (IDLE/FETCH/WAIT/VALID/DONE), L_ROWS=3,
//    L_WINDOW_SIZE=9, window slot index function.
//  - One sub-module: window_shift_register. It holds the 3x3 x P_PIXEL_DEPTH storage and exposes
//    shift, row-select write and packed output.
//  - FSM, counters and capture pipe live in frame_window_reader.
// TESTING (bench: P_COLUMNS=8, behavioural frame_buffer model; pixel(r,c) = {r[3:0],c[3:0]})
//  1. Reset asserted -> every output 0. Deassert with I_START=0 -> O_BUSY stays 0 and no reads.
//  2. I_START 1 cycle, READY=1 -> reads cycles 1-9. First window (center 1) =
//     {00,01,02,10,11,12,20,21,22}, valid cycle 11.
//     Then 6 windows total, centres 1..6, O_DONE pulses once, O_BUSY falls.
//  3. READY=0 for 5 cycles on centre 3 -> window/valid/center stable, O_FB_READ_ENABLE=0.
//     Release -> centre 4 window {03,04,05,13,14,15,23,24,25}.
//  4. I_START pulsed during FETCH and VALID -> ignored; sweep still yields exactly 6 windows.
//  5. I_RESET asserted mid-FETCH of centre 2 -> outputs 0 same cycle.
//     Restart -> first window again centre 1, correct data.
//  6. P_COLUMNS=3 build -> single window centre 1 after 11 cycles; accept -> O_DONE, back to IDLE.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection read path: FSM encoding,
// window geometry and the row/column to window-slot mapping.
package edge_pkg;

  localparam int L_ROWS        = 3;
  localparam int L_WINDOW_SIZE = L_ROWS * L_ROWS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_DONE  = 3'd4
  } fwr_state_t;

  // Slot of row r, window column k (k=0 is centre-1, k=2 is centre+1).
  function automatic int slot_index(input int row, input int k);
    return row * L_ROWS + k;
  endfunction

endpackage

// File: rtl/window_shift_register.sv
// 3x3 pixel window storage. A shift moves every row one slot to the left;
// a write lands in the rightmost slot of the selected row. When both hit
// the same row in one cycle the new pixel wins the rightmost slot.
module window_shift_register
  import edge_pkg::*;
#(
  parameter int P_PIXEL_DEPTH = 8
) (
  input  logic                                   I_CLK,
  input  logic                                   I_RESET,
  input  logic                                   shift,
  input  logic                                   write,
  input  logic [1:0]                             write_row,
  input  logic [P_PIXEL_DEPTH-1:0]               write_data,
  output logic [L_WINDOW_SIZE*P_PIXEL_DEPTH-1:0] window
);

  for (genvar r = 0; r < L_ROWS; r++) begin : g_row
    logic [L_ROWS-1:0][P_PIXEL_DEPTH-1:0] row_q;
    logic                                 row_hit;

    assign row_hit = write && (write_row == 2'(r));

    // Per-row storage: left shift on row-0 capture, right-slot write on hit.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
        row_q <= '0;
      end else begin
        if (shift) begin
          row_q[0] <= row_q[1];
          row_q[1] <= row_q[2];
        end
        if (row_hit) row_q[2] <= write_data;
      end
    end

    assign window[slot_index(r, 0)*P_PIXEL_DEPTH +: L_ROWS*P_PIXEL_DEPTH] = row_q;
  end

endmodule

// File: rtl/frame_window_reader.sv
// Read-side initiator for the 3-row frame buffer. Sweeps columns left to
// right, issuing single-pixel reads row 0,1,2 per column, and assembles the
// 3x3 neighbourhood for the downstream edge kernel via valid/ready.
module frame_window_reader
  import edge_pkg::*;
#(
  parameter int P_COLUMNS     = 640,
  parameter int P_PIXEL_DEPTH = 8
) (
  input  logic                                   I_CLK,
  input  logic                                   I_RESET,
  input  logic                                   I_START,
  output logic [$clog2(P_COLUMNS)-1:0]           O_FB_COL,
  output logic [1:0]                             O_FB_ROW,
  output logic                                   O_FB_READ_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]               I_FB_PIXEL,
  output logic [L_WINDOW_SIZE*P_PIXEL_DEPTH-1:0] O_WINDOW,
  output logic                                   O_WINDOW_VALID,
  input  logic                                   I_WINDOW_READY,
  output logic [$clog2(P_COLUMNS)-1:0]           O_CENTER_COL,
  output logic                                   O_BUSY,
  output logic                                   O_DONE
);

  localparam int              L_CW          = $clog2(P_COLUMNS);
  localparam logic [L_CW-1:0] L_LAST_COL    = L_CW'(P_COLUMNS - 1);
  localparam logic [L_CW-1:0] L_LAST_CENTER = L_CW'(P_COLUMNS - 2);
  localparam logic [3:0]      L_FIRST_FETCH = 4'd9;  // three full columns
  localparam logic [3:0]      L_NEXT_FETCH  = 4'd3;  // one new column

  fwr_state_t      state_q, state_d;
  logic [L_CW-1:0] col_q;
  logic [1:0]      row_q;
  logic [3:0]      cnt_q;
  logic [L_CW-1:0] center_q;
  logic            valid_q;
  logic            cap_valid_q;
  logic [1:0]      cap_row_q;
  logic            read_en;
  logic            accept;
  logic            last_window;

  assign accept      = (state_q == ST_VALID) && I_WINDOW_READY;
  assign last_window = (center_q == L_LAST_CENTER);

  // State register.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    read_en = 1'b0;
    O_BUSY  = 1'b1;
    O_DONE  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        O_BUSY = 1'b0;
        if (I_START) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        read_en = 1'b1;
        if (cnt_q == 4'd1) state_d = ST_WAIT;
      end
      ST_WAIT:  state_d = ST_VALID;
      ST_VALID: if (I_WINDOW_READY) state_d = last_window ? ST_DONE : ST_FETCH;
      ST_DONE: begin
        O_DONE  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch address/count and window centre. The column counter saturates at
  // the last column so it already points at the next column to fetch.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      col_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      center_q <= '0;
    end else begin
      if (state_q == ST_IDLE && I_START) begin
        col_q    <= '0;
        row_q    <= '0;
        cnt_q    <= L_FIRST_FETCH;
        center_q <= L_CW'(1);
      end else if (state_q == ST_FETCH) begin
        cnt_q <= cnt_q - 4'd1;
        if (row_q == 2'(L_ROWS - 1)) begin
          row_q <= '0;
          if (col_q != L_LAST_COL) col_q <= col_q + L_CW'(1);
        end else begin
          row_q <= row_q + 2'd1;
        end
      end else if (accept && !last_window) begin
        cnt_q    <= L_NEXT_FETCH;
        center_q <= center_q + L_CW'(1);
      end
    end
  end

  // Capture pipe tracks the read issued last cycle to match buffer latency.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      cap_valid_q <= 1'b0;
      cap_row_q   <= '0;
    end else begin
      cap_valid_q <= read_en;
      cap_row_q   <= row_q;
    end
  end

  // Window valid is raised on VALID entry and held until accepted.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) valid_q <= 1'b0;
    else         valid_q <= (state_d == ST_VALID);
  end

  window_shift_register #(
    .P_PIXEL_DEPTH (P_PIXEL_DEPTH)
  ) u_window (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .shift      (cap_valid_q && (cap_row_q == 2'd0)),
    .write      (cap_valid_q),
    .write_row  (cap_row_q),
    .write_data (I_FB_PIXEL),
    .window     (O_WINDOW)
  );

  assign O_FB_COL         = col_q;
  assign O_FB_ROW         = row_q;
  assign O_FB_READ_ENABLE = read_en;
  assign O_WINDOW_VALID   = valid_q;
  assign O_CENTER_COL     = center_q;

endmodule
